mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width, even, >= 8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request; accepted only when Ready=1.
REQ-005 SHALL have port MDUControl  input  mdu_operation (3)  one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; sampled with Start.
REQ-006 SHALL have ports SrcA, SrcB  input  DATA_WIDTH  operands; sampled with Start.
REQ-007 SHALL have port Flush  input  1  abandons any in-flight operation.
REQ-008 SHALL have port Ready  output  1  high in IDLE and DONE.
REQ-009 SHALL have port Valid  output  1  one-cycle pulse; MDUResult is valid in that cycle.
REQ-010 SHALL have port MDUResult  output  DATA_WIDTH  result; held until the next Valid.
REQ-011 SHALL have ports ZeroFlag, NegativeFlag  output  1  MDUResult==0 and MDUResult[DATA_WIDTH-1], respectively.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL latch the operands and the operation, then go to MUL or DIV, on a rising edge with Start=1, Ready=1 and Flush=0.
REQ-014 SHALL form the full 2*DATA_WIDTH product in MUL (one cycle), then go to DONE; MUL-class latency from the Start edge to Valid is 2 cycles.
REQ-015 SHALL return from MUL the low word; from MULH the high word with signed x signed; from MULHSU the high word with signed SrcA x unsigned SrcB; from MULHU the high word with unsigned x unsigned.
REQ-016 SHALL divide in DIV with restoring radix-2, one quotient bit per cycle, using a counter of exactly DATA_WIDTH cycles; then go to DONE. Normal division latency is DATA_WIDTH+2 cycles.
REQ-017 SHALL, for signed DIV/REM, divide magnitudes, make the quotient sign the XOR of the operand signs and the remainder sign equal to the dividend sign.
REQ-018 SHALL, on divide-by-zero, return quotient all-ones and remainder = SrcA, skip the iteration, and have latency 2.
REQ-019 SHALL, on signed overflow (SrcA = most-negative, SrcB = -1), return quotient = SrcA and remainder 0, with latency 2.
REQ-020 SHALL assert Valid only in DONE; DONE lasts exactly one cycle.
REQ-021 SHALL go from DONE to IDLE, or directly to MUL/DIV if Start=1 (back-to-back operations).
REQ-022 SHALL ignore Start while Ready=0 (no queueing).
REQ-023 SHALL, on Flush=1 at any edge, go to IDLE with no Valid, leave MDUResult unchanged, and let Flush override a simultaneous Start.
REQ-024 SHALL derive ZeroFlag and NegativeFlag combinationally from the registered MDUResult.

Reset
REQ-025 SHALL, on rst, immediately put the state in IDLE, clear the counter, and set Valid=0, MDUResult=0, ZeroFlag=1, NegativeFlag=0, Ready=1.
REQ-026 SHALL, on rst mid-operation, discard the operation with no Valid afterwards.
REQ-027 SHALL accept Start on the first edge after rst deasserts.

Structure
REQ-028 SHALL place the mdu_operation enum and the state enum in shared package mdu_pkg, and move the existing alu_operation enum there as well.
REQ-029 SHALL isolate the iterative divider datapath (remainder/quotient registers, step counter, sign fix-up) in sub-module mdu_divider, with Start/Done handshake to the FSM.
REQ-030 SHALL contain no latches, and SHALL infer no multiplier other than one DATA_WIDTH+1 signed x DATA_WIDTH+1 signed product.

Verification
REQ-031 SHALL cover: MUL SrcA=7, SrcB=0xFFFFFFFD -> MDUResult 0xFFFFFFEB, Valid 2 cycles after Start, NegativeFlag=1.
REQ-032 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD after 34 cycles; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-034 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0 with ZeroFlag=1, each with latency 2.
REQ-035 SHALL cover: Flush at iteration 10 of a DIV together with Start(MUL 3x4) -> no Valid and MDUResult unchanged for 40 cycles; then Start MUL 3x4 -> 12.
REQ-036 SHALL cover: rst mid-DIV -> IDLE, Valid=0, MDUResult=0, ZeroFlag=1; back-to-back Start in DONE -> Valid 2 cycles after the accepting edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the execute stage: ALU and MDU operation encodings, MDU FSM states,
// and small decode helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_operation;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_operation;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state;

  function automatic logic is_div_op(mdu_operation op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_rem_op(mdu_operation op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_signed_div(mdu_operation op);
    return op inside {MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on magnitudes,
// sign fix-up on the outputs, single-cycle handling of divide-by-zero and signed overflow.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W) + 1;

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt;
  logic          busy, neg_q, neg_r;
  logic          a_neg, b_neg, div_zero, overflow;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    partial, diff;

  always_comb begin
    a_neg    = is_signed & dividend[W-1];
    b_neg    = is_signed & divisor[W-1];
    a_mag    = a_neg ? ('0 - dividend) : dividend;
    b_mag    = b_neg ? ('0 - divisor) : divisor;
    div_zero = (divisor == '0);
    overflow = is_signed & (dividend == {1'b1, {(W-1){1'b0}}}) & (divisor == '1);
    // next dividend bit shifts out of the quotient register into the partial remainder
    partial  = {rem_q, quo_q[W-1]};
    diff     = partial - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (start) begin
        if (div_zero || overflow) begin
          quo_q <= div_zero ? '1 : dividend;
          rem_q <= div_zero ? dividend : '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          done  <= 1'b1;
        end else begin
          rem_q <= '0;
          quo_q <= a_mag;
          dvs_q <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          busy  <= 1'b1;
          cnt   <= CW'(W);
        end
      end else if (busy) begin
        if (!diff[W]) begin
          rem_q <= diff[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= partial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = neg_q ? ('0 - quo_q) : quo_q;
  assign remainder = neg_r ? ('0 - rem_q) : rem_q;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: single-cycle multiply through one shared signed product,
// iterative division delegated to mdu_divider, Start/Ready/Valid handshake with Flush.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [2:0]            MDUControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Ready,
  output logic                  Valid,
  output logic [DATA_WIDTH-1:0] MDUResult,
  output logic                  ZeroFlag,
  output logic                  NegativeFlag
);
  localparam int unsigned W = DATA_WIDTH;

  mdu_state             state;
  mdu_operation         ctl, op_q;
  logic [W-1:0]         a_q, b_q;
  logic                 accept, div_done;
  logic [W-1:0]         quotient, remainder, mul_res;
  logic signed [W:0]    mul_a, mul_b;
  logic signed [2*W-1:0] product;

  assign ctl    = mdu_operation'(MDUControl);
  assign accept = Start & Ready & ~Flush;

  mdu_divider #(.DATA_WIDTH(W)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (accept & is_div_op(ctl)),
    .is_signed (is_signed_div(ctl)),
    .flush     (Flush),
    .dividend  (SrcA),
    .divisor   (SrcB),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // one extra sign bit per operand lets all four multiply flavours share a single signed product
  always_comb begin
    mul_a   = {(op_q inside {MDU_MULH, MDU_MULHSU}) & a_q[W-1], a_q};
    mul_b   = {(op_q == MDU_MULH) & b_q[W-1], b_q};
    product = (2*W)'(mul_a) * (2*W)'(mul_b);
    mul_res = (op_q == MDU_MUL) ? product[W-1:0] : product[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      Valid     <= 1'b0;
      Ready     <= 1'b1;
      MDUResult <= '0;
      op_q      <= MDU_MUL;
      a_q       <= '0;
      b_q       <= '0;
    end else if (Flush) begin
      state <= IDLE;
      Valid <= 1'b0;
      Ready <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          Valid <= 1'b0;
          if (Start) begin
            op_q  <= ctl;
            a_q   <= SrcA;
            b_q   <= SrcB;
            Ready <= 1'b0;
            state <= is_div_op(ctl) ? DIV : MUL;
          end else begin
            Ready <= 1'b1;
            state <= IDLE;
          end
        end
        MUL: begin
          MDUResult <= mul_res;
          Valid     <= 1'b1;
          Ready     <= 1'b1;
          state     <= DONE;
        end
        DIV: begin
          if (div_done) begin
            MDUResult <= is_rem_op(op_q) ? remainder : quotient;
            Valid     <= 1'b1;
            Ready     <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ZeroFlag     = (MDUResult == '0);
  assign NegativeFlag = MDUResult[W-1];

endmodule
